svm_feature_packer: RTL

//   Upstream stage of the V3 SVM classifier. Accepts raw sensor samples one per

---
 rtl/svm_feature_packer.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/svm_feature_packer.sv
// svm_feature_packer
//   Front end of the V3 SVM classifier. Takes raw unsigned sensor samples one
//   per handshake, quantizes each one to FEAT_W bits (right shift, then
//   saturate), and packs N_FEAT of them into the flat vector that feeds the
//   classifier's combinational inp bus. The design is double-buffered: a fill
//   buffer collects the next frame while the output register holds the
//   previous frame for the classifier.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset (released synchronously upstream)
//   s_valid    raw sample valid
//   s_ready    packer can accept a sample (registered)
//   s_data     raw unsigned sample
//   s_last     marks the final sample of a frame
//   m_valid    packed frame valid
//   m_ready    classifier consumes the frame
//   m_data     packed features; feature k at [k*FEAT_W +: FEAT_W]
//   frame_err  one-cycle pulse: a malformed frame was dropped
//   state_dbg  current FSM state (0 FILL, 1 FULL, 2 DISCARD)
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. The source holds valid and data steady until that edge. Valid
// never waits for ready. s_ready comes from a flop and never depends
// combinationally on m_ready.
module svm_feature_packer #(
  parameter int N_FEAT = 6,
  parameter int FEAT_W = 5,
  parameter int RAW_W  = 8,
  parameter int SHIFT  = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [RAW_W-1:0]         s_data,
  input  logic                     s_last,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [N_FEAT*FEAT_W-1:0] m_data,
  output logic                     frame_err,
  output logic [1:0]               state_dbg
);

  localparam int VEC_W = N_FEAT * FEAT_W;
  localparam int CNT_W = (N_FEAT > 1) ? $clog2(N_FEAT) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_FEAT - 1);
  localparam logic [RAW_W-1:0] SAT_RAW  = RAW_W'((1 << FEAT_W) - 1);

  typedef enum logic [1:0] {
    ST_FILL    = 2'd0,
    ST_FULL    = 2'd1,
    ST_DISCARD = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [VEC_W-1:0]   fill_q, fill_d;
  logic [VEC_W-1:0]   data_q, data_d;
  logic               valid_q, valid_d;
  logic               err_q, err_d;
  logic               ready_q;

  logic               accept;
  logic               consume;
  logic [RAW_W-1:0]   shifted;
  logic [FEAT_W-1:0]  q;
  logic [VEC_W-1:0]   fill_written;

  assign accept  = s_valid & ready_q;
  assign consume = valid_q & m_ready;

  // Quantize: shift first, then clamp anything above the largest FEAT_W code.
  always_comb begin
    shifted = s_data >> SHIFT;
    if (shifted > SAT_RAW) q = '1;
    else                   q = shifted[FEAT_W-1:0];
  end

  // The fill buffer with the incoming sample placed at slot cnt. On the
  // completing accept, this vector (not fill_q) goes to the output so the
  // last sample is included without an extra cycle.
  always_comb begin
    fill_written = fill_q;
    for (int k = 0; k < N_FEAT; k++) begin
      if (cnt_q == CNT_W'(k)) fill_written[k*FEAT_W +: FEAT_W] = q;
    end
  end

  // State register, together with the datapath registers it controls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_FILL;
      cnt_q   <= '0;
      fill_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fill_q  <= fill_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      ready_q <= (state_d != ST_FULL);
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    fill_d  = fill_q;
    data_d  = data_q;
    valid_d = consume ? 1'b0 : valid_q;
    err_d   = 1'b0;
    case (state_q)
      ST_FILL: begin
        if (accept) begin
          if (cnt_q == LAST_IDX) begin
            cnt_d = '0;
            if (s_last) begin
              // Complete frame: go straight to the output if it is free or
              // being emptied this edge; otherwise park it in the fill buffer.
              if (!valid_q || m_ready) begin
                data_d  = fill_written;
                valid_d = 1'b1;
                fill_d  = '0;
              end else begin
                fill_d  = fill_written;
                state_d = ST_FULL;
              end
            end else begin
              // Too many samples: drop, then skip to the next s_last.
              fill_d  = '0;
              err_d   = 1'b1;
              state_d = ST_DISCARD;
            end
          end else if (s_last) begin
            // Too few samples: drop the partial frame.
            cnt_d  = '0;
            fill_d = '0;
            err_d  = 1'b1;
          end else begin
            cnt_d  = cnt_q + 1'b1;
            fill_d = fill_written;
          end
        end
      end
      ST_FULL: begin
        if (consume) begin
          data_d  = fill_q;
          valid_d = 1'b1;
          fill_d  = '0;
          state_d = ST_FILL;
        end
      end
      ST_DISCARD: begin
        if (accept && s_last) state_d = ST_FILL;
      end
      default: state_d = ST_FILL;
    endcase
  end

  // Outputs are taken directly from registers.
  always_comb begin
    s_ready   = ready_q;
    m_valid   = valid_q;
    m_data    = data_q;
    frame_err = err_q;
    state_dbg = state_q;
  end

endmodule
